ula_scheduler: RTL and testbench
================================

# ula_scheduler

Round-robin arbiter and sequencer that shares one floating-point ULA (add/mult datapath with start/done handshake) among N requesters. It selects a requester, registers its operands, drives the ULA's reset/start sequence, waits for done, and returns the result to the winner as a one-cycle response. The ULA latches in DONE until it is reset, so the block issues a clearing reset pulse before every launch.

## Interface
- N, 2: number of requesters (2..8).
- TIMEOUT, 40: maximum WAIT cycles before abort (used only with the timeout feature).
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- req  in  N  per-requester request level.
- req_op  in  N  per-requester op (0 = add/sub, 1 = mult).
- req_a, req_b  in  29*N  packed operand magnitudes; requester i at [29*i+28:29*i].
- req_sign_a, req_sign_b  in  N  operand signs.
- gnt  out  N  one-hot, one-cycle acceptance pulse.
- rsp_valid  out  N  one-hot, one-cycle result pulse to the granted requester.
- rsp_c  out  29  result magnitude; held until the next response.
- rsp_sign  out  1  result sign; held with rsp_c.
- rsp_err  out  1  timeout flag, valid with rsp_valid.
- ula_reset, ula_start, ula_op, ula_sign_a, ula_sign_b  out  1  ULA controls.
- ula_a, ula_b  out  29  ULA operands.
- ula_c  in  29; ula_sign_c  in  1; ula_done  in  1  ULA outputs.

## Operation
- States: IDLE, CLR, LAUNCH, WAIT, RESP.
- IDLE: req is sampled only here. If any bit is set, choose the winner round-robin: search from index ptr+1 upward, wrapping. Register the winner's op, a, b and signs into ula_* outputs; set ptr = winner. Go to CLR. With no request, stay in IDLE.
- CLR: gnt[winner]=1 and ula_reset=1 for exactly one cycle. Go to LAUNCH.
- LAUNCH: ula_start=1 for exactly one cycle. Go to WAIT.
- WAIT: stay until ula_done is sampled high. Then capture ula_c into rsp_c, capture ula_sign_c into rsp_sign, clear rsp_err, and go to RESP.
- RESP: rsp_valid[winner]=1 for one cycle. Go to IDLE.
- ula_op, ula_a, ula_b and the ula_sign_* outputs are held constant from CLR through RESP.
- Requester rules:
  - Hold req and operands stable until gnt is seen.
  - Changing operands after gnt has no effect.
  - req still high when the block returns to IDLE counts as a new request.
- Arithmetic is performed entirely by the ULA. The block forwards ula_c and ula_sign_c unmodified; no width change.
- ula_reset = reset OR (state == CLR) OR (timeout abort cycle).
- Reset values:
  - state IDLE; ptr = N-1, so requester 0 wins first.
  - gnt, rsp_valid, rsp_c, rsp_sign and rsp_err are 0.
  - ula_start and all ula operand/op/sign outputs are 0; ula_reset is 1.
- Reset mid-operation aborts at once. No rsp_valid is issued for the in-flight request, and that requester must re-request.

## Timing
- A request first sampled in cycle t gives gnt in t+1 (CLR) and ula_start in t+2.
- ula_done first high in cycle d gives rsp_valid in d+1 and IDLE in d+2.
- A new request can be sampled in d+2, so there is a 3-cycle fixed overhead between back-to-back operations.
- Simultaneous requests: one is granted; the others wait, with no starvation (round-robin).
- ula_done seen outside WAIT is ignored.

## Configuration
- ULA_SCHED_TIMEOUT_EN defined:
  - A WAIT cycle counter (width ≥ clog2(TIMEOUT+1)) clears on entering WAIT.
  - If it reaches TIMEOUT with ula_done still low, go to RESP with rsp_err=1, rsp_c=0, rsp_sign=0, and ula_reset=1 in that RESP cycle.
- Undefined: no counter; WAIT is unbounded; rsp_err is tied to 0.

## Test plan
- N=2, req[0], op=0, a=100, b=28, signs 0/0 -> gnt[0] at t+1, ula_start at t+2, rsp_valid[0] one cycle after ula_done, rsp_c=128, rsp_sign=0.
- req[1], op=0, a=10 sign 0, b=30 sign 1 -> rsp_valid[1], rsp_c=20, rsp_sign=1.
- req[0], op=1, a=b=29'h0400_0000 (mantissa 1.0), signs 1/0 -> rsp_c=29'h0400_0000, rsp_sign=1, done after ≥24 WAIT cycles.
- req=2'b11 held from reset -> grants 0 then 1. Both re-request -> 0 then 1 again. Neither gets two consecutive grants while the other is waiting.
- ULA_SCHED_TIMEOUT_EN, TIMEOUT=8, ula_done stubbed low -> RESP after exactly 8 WAIT cycles with rsp_err=1, rsp_c=0 and ula_reset high in that cycle.
- reset asserted during WAIT -> next cycle: state IDLE, all outputs 0 except ula_reset=1, no rsp_valid; next request is serviced normally.

Source files
------------

// File: rtl/ula_scheduler.sv
// ula_scheduler
//   Round-robin arbiter and sequencer sharing one floating-point ULA
//   (add/mult datapath with start/done handshake) among N requesters.
//   Per operation: IDLE picks a winner and registers its operands, CLR
//   pulses gnt and ula_reset (the ULA latches DONE until reset, so every
//   launch is preceded by a clearing reset), LAUNCH pulses ula_start, WAIT
//   holds until ula_done, RESP returns the result as a one-cycle pulse.
//
// Handshake: a requester holds req and its operands until it sees its gnt
//   bit. Operands are captured on the same edge that gnt rises, so later
//   changes have no effect. req still high back in IDLE is a new request.
//   rsp_valid is a one-cycle pulse; rsp_c/rsp_sign hold until the next
//   response.
//
// Configuration macro: ULA_SCHED_TIMEOUT_EN. When defined, WAIT is bounded
//   by TIMEOUT cycles and an expired wait answers with rsp_err=1, rsp_c=0,
//   rsp_sign=0 and a ula_reset pulse in the RESP cycle. When undefined,
//   WAIT is unbounded and rsp_err is constant 0.
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   req, req_op                     per-requester request level and op
//   req_a, req_b                    packed 29-bit magnitudes, slot i at [29*i +: 29]
//   req_sign_a, req_sign_b          per-requester operand signs
//   gnt, rsp_valid                  one-hot one-cycle pulses
//   rsp_c, rsp_sign, rsp_err        response data and timeout flag
//   ula_reset, ula_start, ula_op,
//   ula_a, ula_b, ula_sign_a/b      ULA controls and operands
//   ula_c, ula_sign_c, ula_done     ULA results
//   dbg_state                       current FSM state (IDLE=0 .. RESP=4)
module ula_scheduler #(
  parameter int N       = 2,
  parameter int TIMEOUT = 40
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N-1:0]      req,
  input  logic [N-1:0]      req_op,
  input  logic [29*N-1:0]   req_a,
  input  logic [29*N-1:0]   req_b,
  input  logic [N-1:0]      req_sign_a,
  input  logic [N-1:0]      req_sign_b,
  output logic [N-1:0]      gnt,
  output logic [N-1:0]      rsp_valid,
  output logic [28:0]       rsp_c,
  output logic              rsp_sign,
  output logic              rsp_err,
  output logic              ula_reset,
  output logic              ula_start,
  output logic              ula_op,
  output logic              ula_sign_a,
  output logic              ula_sign_b,
  output logic [28:0]       ula_a,
  output logic [28:0]       ula_b,
  input  logic [28:0]       ula_c,
  input  logic              ula_sign_c,
  input  logic              ula_done,
  output logic [2:0]        dbg_state
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLR    = 3'd1,
    S_LAUNCH = 3'd2,
    S_WAIT   = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  state_t          r_state, w_next;
  logic [PW-1:0]   r_ptr, r_win, w_win;
  logic            w_found;
  logic            r_op, r_sign_a, r_sign_b, r_rsp_sign;
  logic [28:0]     r_a, r_b, r_rsp_c;

`ifdef ULA_SCHED_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0]   r_cnt;
  logic            r_rsp_err;
  logic            w_tmo;
`endif

  // (p + k) mod N, for N that need not be a power of two.
  function automatic logic [PW-1:0] wrap_idx(input logic [PW-1:0] p, input int k);
    int s;
    s = (int'(p) + k) % N;
    return PW'(s);
  endfunction

  // Round-robin search starting just after the last winner; k=N comes back
  // to the last winner itself so a lone requester is still served.
  always_comb begin
    w_found = 1'b0;
    w_win   = r_ptr;
    for (int k = 1; k <= N; k++) begin
      if (!w_found && req[wrap_idx(r_ptr, k)]) begin
        w_found = 1'b1;
        w_win   = wrap_idx(r_ptr, k);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    gnt       = '0;
    rsp_valid = '0;
    ula_start = 1'b0;
`ifdef ULA_SCHED_TIMEOUT_EN
    w_tmo     = 1'b0;
`endif
    case (r_state)
      S_IDLE:   if (w_found) w_next = S_CLR;
      S_CLR: begin
        gnt[r_win] = 1'b1;
        w_next     = S_LAUNCH;
      end
      S_LAUNCH: begin
        ula_start = 1'b1;
        w_next    = S_WAIT;
      end
      S_WAIT: begin
        if (ula_done) w_next = S_RESP;
`ifdef ULA_SCHED_TIMEOUT_EN
        // r_cnt counts completed WAIT cycles; this is the TIMEOUT-th one.
        else if (r_cnt == CW'(TIMEOUT - 1)) begin
          w_next = S_RESP;
          w_tmo  = 1'b1;
        end
`endif
      end
      S_RESP: begin
        rsp_valid[r_win] = 1'b1;
        w_next           = S_IDLE;
      end
      default:  w_next = S_IDLE;
    endcase
  end

  // Operand capture happens only on the IDLE->CLR edge, so operands stay
  // frozen from CLR through RESP regardless of requester activity.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr      <= PW'(N - 1);
      r_win      <= '0;
      r_op       <= 1'b0;
      r_a        <= '0;
      r_b        <= '0;
      r_sign_a   <= 1'b0;
      r_sign_b   <= 1'b0;
      r_rsp_c    <= '0;
      r_rsp_sign <= 1'b0;
    end else begin
      if (r_state == S_IDLE && w_found) begin
        r_win    <= w_win;
        r_ptr    <= w_win;
        r_op     <= req_op[w_win];
        r_a      <= req_a[int'(w_win)*29 +: 29];
        r_b      <= req_b[int'(w_win)*29 +: 29];
        r_sign_a <= req_sign_a[w_win];
        r_sign_b <= req_sign_b[w_win];
      end
      if (r_state == S_WAIT && ula_done) begin
        r_rsp_c    <= ula_c;
        r_rsp_sign <= ula_sign_c;
      end
`ifdef ULA_SCHED_TIMEOUT_EN
      else if (w_tmo) begin
        r_rsp_c    <= '0;
        r_rsp_sign <= 1'b0;
      end
`endif
    end
  end

`ifdef ULA_SCHED_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt     <= '0;
      r_rsp_err <= 1'b0;
    end else begin
      if (r_state == S_LAUNCH)    r_cnt <= '0;
      else if (r_state == S_WAIT) r_cnt <= r_cnt + CW'(1);
      if (r_state == S_WAIT && ula_done) r_rsp_err <= 1'b0;
      else if (w_tmo)                    r_rsp_err <= 1'b1;
    end
  end

  // The aborted ULA may still be mid-operation; the RESP-cycle reset
  // puts it back into a known state.
  assign ula_reset = reset | (r_state == S_CLR) | ((r_state == S_RESP) & r_rsp_err);
  assign rsp_err   = r_rsp_err;
`else
  assign ula_reset = reset | (r_state == S_CLR);
  assign rsp_err   = 1'b0;
`endif

  assign ula_op     = r_op;
  assign ula_a      = r_a;
  assign ula_b      = r_b;
  assign ula_sign_a = r_sign_a;
  assign ula_sign_b = r_sign_b;
  assign rsp_c      = r_rsp_c;
  assign rsp_sign   = r_rsp_sign;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_ula_scheduler.sv
module tb_ula_scheduler;
  localparam int N = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req, req_op, req_sign_a, req_sign_b;
  logic [29*N-1:0] req_a, req_b;
  logic [N-1:0]    gnt, rsp_valid;
  logic [28:0]     rsp_c, ula_a, ula_b, ula_c;
  logic            rsp_sign, rsp_err;
  logic            ula_reset, ula_start, ula_op, ula_sign_a, ula_sign_b;
  logic            ula_sign_c, ula_done;
  logic [2:0]      dbg_state;

  localparam logic [2:0] ST_IDLE = 3'd0, ST_WAIT = 3'd3, ST_RESP = 3'd4;

  int total = 0;
  int bad   = 0;
  logic [28:0] exp_q[$];

  ula_scheduler #(.N(N), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .req(req), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_sign_a(req_sign_a), .req_sign_b(req_sign_b),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_c(rsp_c), .rsp_sign(rsp_sign),
    .rsp_err(rsp_err), .ula_reset(ula_reset), .ula_start(ula_start),
    .ula_op(ula_op), .ula_sign_a(ula_sign_a), .ula_sign_b(ula_sign_b),
    .ula_a(ula_a), .ula_b(ula_b), .ula_c(ula_c), .ula_sign_c(ula_sign_c),
    .ula_done(ula_done), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic set_req(input int idx, input bit op, input logic [28:0] a, input bit sa,
                         input logic [28:0] b, input bit sb);
    req_op[idx]          = op;
    req_a[29*idx +: 29]  = a;
    req_b[29*idx +: 29]  = b;
    req_sign_a[idx]      = sa;
    req_sign_b[idx]      = sb;
    req[idx]             = 1'b1;
  endtask

  // Full operation: ULA raises done after `lat` WAIT cycles with result c/sc.
  task automatic do_op(input int idx, input bit op, input logic [28:0] a, input bit sa,
                       input logic [28:0] b, input bit sb, input logic [28:0] c,
                       input bit sc, input int lat, input string nm);
    logic [N-1:0] exp_g;
    logic [28:0]  exp_c;
    exp_g = N'(1) << idx;
    set_req(idx, op, a, sa, b, sb);
    tick();  // CLR
    total++; if (gnt !== exp_g) begin bad++; $display("FAIL %s gnt: got %b want %b", nm, gnt, exp_g); end
    total++; if (ula_reset !== 1'b1) begin bad++; $display("FAIL %s clr_reset: got %b want 1", nm, ula_reset); end
    total++; if ({ula_op, ula_sign_a, ula_sign_b, ula_a, ula_b} !== {op, sa, sb, a, b}) begin
      bad++; $display("FAIL %s operands: got op=%b sa=%b sb=%b a=%h b=%h want op=%b sa=%b sb=%b a=%h b=%h",
                      nm, ula_op, ula_sign_a, ula_sign_b, ula_a, ula_b, op, sa, sb, a, b);
    end
    req[idx] = 1'b0;
    req_a[29*idx +: 29] = 29'($urandom);
    req_b[29*idx +: 29] = 29'($urandom);
    req_op[idx] = ~op;
    tick();  // LAUNCH
    total++; if ({ula_start, ula_reset, gnt} !== {2'b10, N'(0)}) begin
      bad++; $display("FAIL %s launch: got start=%b rst=%b gnt=%b want start=1 rst=0 gnt=0", nm, ula_start, ula_reset, gnt);
    end
    exp_q.push_back(c);
    repeat (lat) tick();
    total++; if ({dbg_state, rsp_valid, ula_start} !== {ST_WAIT, N'(0), 1'b0}) begin
      bad++; $display("FAIL %s wait: got state=%0d rv=%b start=%b want state=3 rv=0 start=0", nm, dbg_state, rsp_valid, ula_start);
    end
    ula_c = c; ula_sign_c = sc; ula_done = 1'b1;
    tick();  // RESP
    exp_c = exp_q.pop_front();
    total++; if (rsp_valid !== exp_g) begin bad++; $display("FAIL %s rsp_valid: got %b want %b", nm, rsp_valid, exp_g); end
    total++; if ({rsp_c, rsp_sign, rsp_err} !== {exp_c, sc, 1'b0}) begin
      bad++; $display("FAIL %s result: got c=%h s=%b e=%b want c=%h s=%b e=0", nm, rsp_c, rsp_sign, rsp_err, exp_c, sc);
    end
    total++; if ({ula_op, ula_a, ula_b} !== {op, a, b}) begin
      bad++; $display("FAIL %s hold: got op=%b a=%h b=%h want op=%b a=%h b=%h", nm, ula_op, ula_a, ula_b, op, a, b);
    end
    ula_done = 1'b0; ula_c = 29'($urandom);
    tick();  // IDLE
    total++; if ({dbg_state, rsp_valid, rsp_c} !== {ST_IDLE, N'(0), exp_c}) begin
      bad++; $display("FAIL %s idle: got state=%0d rv=%b c=%h want state=0 rv=0 c=%h", nm, dbg_state, rsp_valid, rsp_c, exp_c);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req = '0; req_op = '0; req_a = '0; req_b = '0;
    req_sign_a = '0; req_sign_b = '0; ula_c = '0; ula_sign_c = 1'b0; ula_done = 1'b0;
    tick(); tick();
    total++; if ({dbg_state, gnt, rsp_valid, rsp_c, rsp_sign, rsp_err} !== '0) begin
      bad++; $display("FAIL reset outs: got st=%0d gnt=%b rv=%b c=%h s=%b e=%b want all 0", dbg_state, gnt, rsp_valid, rsp_c, rsp_sign, rsp_err);
    end
    total++; if ({ula_start, ula_op, ula_sign_a, ula_sign_b, ula_a, ula_b} !== '0) begin
      bad++; $display("FAIL reset ula: got start=%b op=%b a=%h b=%h want 0", ula_start, ula_op, ula_a, ula_b);
    end
    total++; if (ula_reset !== 1'b1) begin bad++; $display("FAIL reset ula_reset: got %b want 1", ula_reset); end
    reset = 1'b0;
    tick();
    total++; if (ula_reset !== 1'b0) begin bad++; $display("FAIL post_reset ula_reset: got %b want 0", ula_reset); end
  endtask

  task automatic test_add();
    do_op(0, 1'b0, 29'd100, 1'b0, 29'd28, 1'b0, 29'd128, 1'b0, 3, "add0");
  endtask

  task automatic test_sub();
    do_op(1, 1'b0, 29'd10, 1'b0, 29'd30, 1'b1, 29'd20, 1'b1, 2, "add1");
  endtask

  task automatic test_mult();
    do_op(0, 1'b1, 29'h0400_0000, 1'b1, 29'h0400_0000, 1'b0, 29'h0400_0000, 1'b1, 24, "mul0");
  endtask

  // A latched done from the ULA must not complete anything before WAIT.
  task automatic test_done_ignored();
    ula_done = 1'b1; ula_c = 29'h0ABC; ula_sign_c = 1'b0;
    tick(); tick();
    total++; if ({dbg_state, rsp_valid} !== {ST_IDLE, N'(0)}) begin
      bad++; $display("FAIL done_idle: got st=%0d rv=%b want st=0 rv=0", dbg_state, rsp_valid);
    end
    set_req(1, 1'b0, 29'd5, 1'b0, 29'd6, 1'b0);
    tick(); req = '0;  // CLR
    tick();            // LAUNCH
    tick();            // WAIT
    total++; if ({dbg_state, rsp_valid} !== {ST_WAIT, N'(0)}) begin
      bad++; $display("FAIL done_early: got st=%0d rv=%b want st=3 rv=0", dbg_state, rsp_valid);
    end
    tick();            // RESP
    total++; if ({rsp_valid, rsp_c} !== {2'b10, 29'h0ABC}) begin
      bad++; $display("FAIL done_resp: got rv=%b c=%h want rv=10 c=0abc", rsp_valid, rsp_c);
    end
    ula_done = 1'b0;
    tick();
  endtask

  task automatic test_round_robin();
    int exp_w[4] = '{0, 1, 0, 1};
    logic [N-1:0] eg;
    reset = 1'b1;
    set_req(0, 1'b0, 29'd1, 1'b0, 29'd2, 1'b0);
    set_req(1, 1'b0, 29'd3, 1'b0, 29'd4, 1'b0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      eg = N'(1) << exp_w[i];
      tick();  // CLR
      total++; if (gnt !== eg) begin bad++; $display("FAIL rr%0d gnt: got %b want %b", i, gnt, eg); end
      tick(); tick();
      ula_c = 29'(i + 7); ula_done = 1'b1;
      tick();  // RESP
      total++; if ({rsp_valid, rsp_c} !== {eg, 29'(i + 7)}) begin
        bad++; $display("FAIL rr%0d rsp: got rv=%b c=%h want rv=%b c=%h", i, rsp_valid, rsp_c, eg, 29'(i + 7));
      end
      ula_done = 1'b0;
      tick();  // IDLE
    end
    req = '0;
    tick();
  endtask

  task automatic test_reset_mid();
    set_req(1, 1'b1, 29'd9, 1'b1, 29'd11, 1'b1);
    tick(); req = '0;
    tick(); tick(); tick();  // in WAIT
    reset = 1'b1;
    tick();
    total++; if ({dbg_state, gnt, rsp_valid, ula_start, ula_op, ula_a, ula_b, rsp_c} !== '0) begin
      bad++; $display("FAIL rst_mid outs: got st=%0d gnt=%b rv=%b start=%b a=%h c=%h want 0", dbg_state, gnt, rsp_valid, ula_start, ula_a, rsp_c);
    end
    total++; if (ula_reset !== 1'b1) begin bad++; $display("FAIL rst_mid ula_reset: got %b want 1", ula_reset); end
    tick();
    reset = 1'b0;
    tick();
    total++; if (rsp_valid !== '0) begin bad++; $display("FAIL rst_mid no_rsp: got %b want 0", rsp_valid); end
    do_op(1, 1'b0, 29'd40, 1'b0, 29'd2, 1'b0, 29'd42, 1'b0, 1, "after_rst");
  endtask

`ifdef ULA_SCHED_TIMEOUT_EN
  task automatic test_timeout();
    ula_done = 1'b0;
    set_req(0, 1'b1, 29'd3, 1'b0, 29'd3, 1'b0);
    tick(); req = '0;  // CLR
    tick();            // LAUNCH
    for (int i = 0; i < 8; i++) begin
      tick();
      total++; if ({dbg_state, rsp_valid} !== {ST_WAIT, N'(0)}) begin
        bad++; $display("FAIL tmo wait%0d: got st=%0d rv=%b want st=3 rv=0", i, dbg_state, rsp_valid);
      end
    end
    tick();            // RESP
    total++; if ({dbg_state, rsp_valid, rsp_err, rsp_c, rsp_sign, ula_reset} !== {ST_RESP, 2'b01, 1'b1, 29'd0, 1'b0, 1'b1}) begin
      bad++; $display("FAIL tmo resp: got st=%0d rv=%b e=%b c=%h s=%b rst=%b want st=4 rv=01 e=1 c=0 s=0 rst=1",
                      dbg_state, rsp_valid, rsp_err, rsp_c, rsp_sign, ula_reset);
    end
    tick();
    total++; if ({dbg_state, ula_reset} !== {ST_IDLE, 1'b0}) begin
      bad++; $display("FAIL tmo idle: got st=%0d rst=%b want st=0 rst=0", dbg_state, ula_reset);
    end
  endtask
`else
  task automatic test_timeout();
    ula_done = 1'b0;
    set_req(0, 1'b1, 29'd3, 1'b0, 29'd3, 1'b0);
    tick(); req = '0;
    tick();
    repeat (50) tick();
    total++; if ({dbg_state, rsp_valid, rsp_err} !== {ST_WAIT, N'(0), 1'b0}) begin
      bad++; $display("FAIL no_tmo wait: got st=%0d rv=%b e=%b want st=3 rv=0 e=0", dbg_state, rsp_valid, rsp_err);
    end
    ula_c = 29'd9; ula_done = 1'b1;
    tick();
    total++; if ({rsp_valid, rsp_c, rsp_err} !== {2'b01, 29'd9, 1'b0}) begin
      bad++; $display("FAIL no_tmo resp: got rv=%b c=%h e=%b want rv=01 c=9 e=0", rsp_valid, rsp_c, rsp_err);
    end
    ula_done = 1'b0;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_mult();
    test_done_ignored();
    test_round_robin();
    test_reset_mid();
    test_timeout();
    total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL scoreboard leftover: got %0d want 0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
